// File: rtl/karatsuba8_dot.sv
// karatsuba8_dot: fixed-length dot-product controller wrapped around the
// 8-bit Karatsuba multiplier. Takes operand pairs over a valid/ready
// handshake and sends each pair to the multiplier over start/done. It adds
// up the N products and presents one sum per group on a valid/ready output.
module karatsuba8_dot #(
    parameter int unsigned N     = 4,
    parameter int unsigned ACC_W = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_x,
    input  logic [7:0]       in_y,
    output logic             mul_start,
    input  logic             mul_done,
    output logic [7:0]       mul_x,
    output logic [7:0]       mul_y,
    input  logic [15:0]      mul_r,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum
);

    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] sum_nx;
    logic             accept;
    logic             take_done;
    logic             last_pair;

    assign prod_ext  = {{(ACC_W-16){1'b0}}, mul_r};
    assign sum_nx    = acc + prod_ext;
    assign accept    = (state == S_IDLE) && in_valid;
    assign take_done = (state == S_WAIT) && mul_done;
    assign last_pair = (cnt == LAST);

    // Handshake outputs are decoded from state only; in_ready is held low
    // while reset is asserted so the block never advertises space in reset.
    assign in_ready  = (state == S_IDLE) && rst;
    assign mul_start = (state == S_START);
    assign out_valid = (state == S_OUT);

    // Next-state selection.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (in_valid)  state_nx = S_START;
            S_START:                state_nx = S_WAIT;
            S_WAIT:  if (mul_done)  state_nx = last_pair ? S_OUT : S_IDLE;
            S_OUT:   if (out_ready) state_nx = S_IDLE;
            default:                state_nx = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Operand registers: loaded only on acceptance, so they stay stable
    // from the start pulse through the done cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_x <= '0;
            mul_y <= '0;
        end else if (accept) begin
            mul_x <= in_x;
            mul_y <= in_y;
        end
    end

    // Accumulator and pair counter; both clear when the group completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
            cnt <= '0;
        end else if (take_done) begin
            if (last_pair) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= sum_nx;
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Result register: written once per group and held through backpressure.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_sum <= '0;
        end else if (take_done && last_pair) begin
            out_sum <= sum_nx;
        end
    end

endmodule

// File: tb/tb_karatsuba8_dot.sv
// Directed testbench for karatsuba8_dot with a variable-latency
// multiplier model standing in for the Karatsuba core.
module tb_karatsuba8_dot;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_x;
    logic [7:0]  in_y;
    logic        mul_start;
    logic        mul_done;
    logic [7:0]  mul_x;
    logic [7:0]  mul_y;
    logic [15:0] mul_r;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] out_sum;

    int errors = 0;
    int checks = 0;
    int starts = 0;
    int lat    = 3;

    always #5 clk = ~clk;

    karatsuba8_dot #(.N(4), .ACC_W(18)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .mul_start (mul_start),
        .mul_done  (mul_done),
        .mul_x     (mul_x),
        .mul_y     (mul_y),
        .mul_r     (mul_r),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Multiplier model: done is a one-cycle level, lat cycles after start.
    initial begin
        logic [7:0] lx;
        logic [7:0] ly;
        mul_done = 1'b0;
        mul_r    = '0;
        forever begin
            @(negedge clk);
            mul_done = 1'b0;
            if (mul_start) begin
                starts++;
                lx = mul_x;
                ly = mul_y;
                for (int i = 1; i < lat; i++) begin
                    @(negedge clk);
                    if (rst) begin
                        check("mul_x_stable", {24'd0, mul_x}, {24'd0, lx});
                        check("mul_y_stable", {24'd0, mul_y}, {24'd0, ly});
                    end
                end
                @(negedge clk);
                mul_done = 1'b1;
                mul_r    = 16'(lx) * 16'(ly);
            end
        end
    end

    task automatic send_pair(input logic [7:0] x, input logic [7:0] y);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
        in_valid = 1'b1;
        in_x     = x;
        in_y     = y;
        @(negedge clk);
        in_valid = 1'b0;
        check("in_ready_low_after_accept", {31'd0, in_ready}, 32'd0);
        check("mul_x_latched", {24'd0, mul_x}, {24'd0, x});
        check("mul_y_latched", {24'd0, mul_y}, {24'd0, y});
    endtask

    task automatic get_result(input string tag, input logic [17:0] exp);
        int n;
        n = 0;
        while (!out_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("out_valid_timeout", {31'd0, out_valid}, 32'd1);
        check(tag, {14'd0, out_sum}, {14'd0, exp});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_drop", {31'd0, out_valid}, 32'd0);
        check("in_ready_after_out", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_x      = '0;
        in_y      = '0;
        out_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_mul_start", {31'd0, mul_start}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_sum", {14'd0, out_sum}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

        // Basic dot product: 1 + 6 + 65025 + 0
        starts = 0;
        lat = 3;
        send_pair(8'd1, 8'd1);
        send_pair(8'd2, 8'd3);
        send_pair(8'd255, 8'd255);
        send_pair(8'd0, 8'd77);
        get_result("basic_sum", 18'd65032);
        check("basic_starts", starts, 32'd4);

        // Maximum operands, no wrap
        for (int i = 0; i < 4; i++) send_pair(8'd255, 8'd255);
        get_result("max_sum", 18'd260100);

        // Backpressure: 4 x (2,2) = 16 held for 5 cycles
        lat = 2;
        for (int i = 0; i < 4; i++) send_pair(8'd2, 8'd2);
        for (int n = 0; n < 300 && !out_valid; n++) @(negedge clk);
        starts = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            in_x     = 8'd99;
            in_y     = 8'd99;
            @(negedge clk);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_out_sum", {14'd0, out_sum}, 32'd16);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        check("bp_no_starts", starts, 32'd0);
        get_result("bp_sum", 18'd16);

        // Variable latency, gaps, two independent groups
        lat = 5;  send_pair(8'd3, 8'd5);
        repeat (2) @(negedge clk);
        lat = 12; send_pair(8'd7, 8'd11);
        lat = 3;  send_pair(8'd100, 8'd200);
        repeat (4) @(negedge clk);
        lat = 9;  send_pair(8'd13, 8'd17);
        get_result("var_group1", 18'd20313);
        lat = 4;  send_pair(8'd250, 8'd4);
        lat = 7;  send_pair(8'd9, 8'd9);
        repeat (1) @(negedge clk);
        lat = 11; send_pair(8'd128, 8'd128);
        lat = 3;  send_pair(8'd1, 8'd255);
        get_result("var_group2", 18'd17720);

        // Reset during WAIT of the third pair
        lat = 3;
        send_pair(8'd9, 8'd9);
        send_pair(8'd9, 8'd9);
        lat = 10;
        send_pair(8'd9, 8'd9);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_mul_start", {31'd0, mul_start}, 32'd0);
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("mid_rst_mul_x", {24'd0, mul_x}, 32'd0);
        check("mid_rst_mul_y", {24'd0, mul_y}, 32'd0);
        check("mid_rst_out_sum", {14'd0, out_sum}, 32'd0);
        repeat (15) @(negedge clk);
        rst = 1'b1;
        lat = 4;
        send_pair(8'd1, 8'd2);
        send_pair(8'd3, 8'd4);
        send_pair(8'd5, 8'd6);
        send_pair(8'd7, 8'd8);
        get_result("post_rst_sum", 18'd100);

        // Fast multiplier response: 200 + 255 + 256 + 0
        lat = 1;
        send_pair(8'd10, 8'd20);
        send_pair(8'd255, 8'd1);
        send_pair(8'd16, 8'd16);
        send_pair(8'd0, 8'd0);
        get_result("fast_sum", 18'd711);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL global_timeout");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/karatsuba8_dot.md
Name: karatsuba8_dot

Overview:
- Fixed-length dot-product controller placed around the 8-bit Karatsuba multiplier.
- Accepts a stream of operand pairs over a valid/ready handshake and sends each pair to the multiplier through start/done.
- Accumulates the 16-bit products and emits one sum per N pairs on a valid/ready output.
- Sits directly upstream of the multiplier (drives its start/X/Y) and downstream of it (consumes its done/R).

Parameters:
- N, 4: operand pairs per dot product; must be at least 2.
- ACC_W, 18: accumulator and output width; must be at least 16+ceil(log2 N).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block can take a pair.
- in_x  in  8  unsigned operand X.
- in_y  in  8  unsigned operand Y.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_done  in  1  multiplier finished; mul_r is valid while this is high.
- mul_x  out  8  registered X to the multiplier.
- mul_y  out  8  registered Y to the multiplier.
- mul_r  in  16  product from the multiplier.
- out_valid  out  1  dot-product result present.
- out_ready  in  1  consumer takes the result.
- out_sum  out  ACC_W  dot-product result.

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE; acc, cnt, mul_x, mul_y and out_sum are cleared to 0.
  - mul_start=0, out_valid=0.
  - in_ready=1 from the first cycle after rst deasserts.
  - Reset mid-operation aborts the operation; the partial sum and the pair in flight are discarded and not reported.
- FSM states: IDLE, START, WAIT, OUT.
  - IDLE: in_ready=1. On in_valid=1, latch in_x into mul_x and in_y into mul_y, then go to START.
  - START: mul_start=1 for exactly one cycle, then go to WAIT. mul_done is ignored in this state.
  - WAIT: hold until mul_done=1. In the mul_done cycle:
    - if cnt<N-1: acc <= acc+mul_r, cnt <= cnt+1, go to IDLE.
    - if cnt=N-1: out_sum <= acc+mul_r, acc <= 0, cnt <= 0, go to OUT.
  - OUT: out_valid=1 and out_sum held stable. On out_ready=1, go to IDLE; out_valid drops in the following cycle.
- in_ready is 1 only in IDLE and depends only on state, never on in_valid.
- mul_start is 0 in every state except START.
- Exactly one mul_start pulse per accepted pair.
- mul_x and mul_y change only on acceptance in IDLE, so they are stable from START through the mul_done cycle.
- Multiplier contract: mul_done is a level. The multiplier must drop it no later than the cycle after mul_start, so the first WAIT cycle never sees a stale done.
- Arithmetic:
  - Unsigned; mul_r is zero-extended to ACC_W.
  - The sum wraps modulo 2^ACC_W. With the default parameters overflow is impossible: the maximum is 4×65025=260100, below 2^18.
- Latency:
  - A pair accepted in cycle t produces mul_start in t+1; WAIT begins in t+2.
  - out_valid rises in the cycle after the N-th mul_done.
  - The next pair can be accepted in the cycle after mul_done (non-final pair) or after the out handshake (final pair).
- Backpressure: while out_valid=1 and out_ready=0, no pairs are accepted and out_sum does not change.
- Out-of-state inputs: in_valid outside IDLE and out_ready outside OUT have no effect.

Test Plan:
- Basic dot product (N=4), pairs (1,1),(2,3),(255,255),(0,77) → single out_valid with out_sum=65032; exactly 4 mul_start pulses; in_ready=0 from acceptance until the done/handshake cycle.
- Maximum values, 4×(255,255) → out_sum=260100; no wrap.
- Output backpressure: out_ready held 0 for 5 cycles after out_valid rises → out_valid and out_sum stay stable, in_ready=0, in_valid pulses ignored; out_ready=1 → out_valid=0 the next cycle, in_ready=1.
- Variable-latency multiplier model (mul_done after 3..12 cycles, mul_r=mul_x*mul_y) plus random in_valid gaps → mul_x/mul_y stable between start and done; 8 pairs give two correct, independent sums (acc cleared between groups).
- Reset mid-operation: assert rst=0 during WAIT of the 3rd pair → all outputs 0 immediately (async); the next 4 pairs (1,2),(3,4),(5,6),(7,8) → out_sum=100 with no residue from before reset.
- Integration with the real karatsuba8 (start/done/X/Y/R wired to mul_*) → pairs (10,20),(255,1),(16,16),(0,0) → out_sum=711.
